// File: rtl/grad_pkg.sv
// grad_pkg -- shared constants and beat type for the gradient-energy stage.
//   GW      : signed gradient width (Sobel on 8-bit pixels needs +/-1020)
//   RW      : radical width, 2*GW-1, matches the sqrt stage's radical input
//   MAG_MAX : largest magnitude after clamping the most negative gradient
//   grad_beat_t : radical payload plus frame markers, one output beat
package grad_pkg;
    localparam int GW      = 11;
    localparam int RW      = 2 * GW - 1;
    localparam int MAG_MAX = (1 << (GW - 1)) - 1;

    typedef struct packed {
        logic [RW-1:0] radical;
        logic          sof;
        logic          eof;
    } grad_beat_t;
endpackage

// File: rtl/grad_pipe_stage.sv
// grad_pipe_stage -- one valid/ready register slice with bubble collapsing.
// The slice loads whenever it is empty or the next slice is loading, so a
// hole anywhere in the pipe is squeezed out without waiting for the output.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_valid       : upstream beat valid
//   i_data        : upstream payload (W bits)
//   i_next_load   : next slice is loading (or downstream ready for the last slice)
//   o_load        : this slice loads this cycle (acts as upstream ready)
//   o_valid       : slice holds a beat
//   o_data        : held payload
module grad_pipe_stage #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    input  logic         i_next_load,
    output logic         o_load,
    output logic         o_valid,
    output logic [W-1:0] o_data
);
    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_load  = !r_valid || i_next_load;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Payload only moves on a real beat so a stalled or drained slice keeps
    // its last value visible instead of picking up idle input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end
endmodule

// File: rtl/grad_mag_sq.sv
// grad_mag_sq -- three-stage pipeline computing the radical gx^2 + gy^2 from a
// signed Sobel gradient pair, with frame markers carried alongside.
// Optional per-frame peak monitor enabled by defining GRAD_PEAK_EN.
// Ports:
//   clk_main            : clock, rising edge
//   sys_rst             : asynchronous active-high reset
//   s_valid/s_ready     : input handshake
//   s_gx, s_gy          : signed gradients (GW bits)
//   s_sof, s_eof        : input frame markers
//   m_valid/m_ready     : output handshake
//   m_radical           : unsigned gx^2 + gy^2 (RW bits)
//   m_sof, m_eof        : output frame markers aligned with m_radical
//   peak, peak_valid    : last completed frame's max radical and its update
//                         pulse (GRAD_PEAK_EN only)
module grad_mag_sq
    import grad_pkg::*;
#(
    parameter int GW = grad_pkg::GW,
    parameter int RW = grad_pkg::RW
) (
    input  logic                 clk_main,
    input  logic                 sys_rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [GW-1:0] s_gx,
    input  logic signed [GW-1:0] s_gy,
    input  logic                 s_sof,
    input  logic                 s_eof,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [RW-1:0]        m_radical,
    output logic                 m_sof,
    output logic                 m_eof
`ifdef GRAD_PEAK_EN
    ,
    output logic [RW-1:0]        peak,
    output logic                 peak_valid
`endif
);
    localparam int MW  = GW - 1;
    localparam int SW  = 2 * GW - 2;
    localparam int P1W = 2 * MW + 2;
    localparam int P2W = 2 * SW + 2;
    localparam int P3W = RW + 2;
    localparam logic signed [GW-1:0] GRAD_MIN = {1'b1, {(GW-1){1'b0}}};

    if (RW != 2 * GW - 1) begin : g_bad_rw
        $error("grad_mag_sq: RW must equal 2*GW-1");
    end

    // The most negative gradient has no positive twin in GW bits; pinning it
    // to the largest magnitude keeps the sum of squares below 2^RW.
    function automatic logic [MW-1:0] clamp_mag(input logic signed [GW-1:0] v);
        if (v == GRAD_MIN) begin
            return {MW{1'b1}};
        end else if (v[GW-1]) begin
            return MW'(-v);
        end else begin
            return v[MW-1:0];
        end
    endfunction

    logic           w_load_p1, w_load_p2, w_load_p3;
    logic           w_vld_p1, w_vld_p2;
    logic [P1W-1:0] w_din_p1, w_data_p1;
    logic [P2W-1:0] w_din_p2, w_data_p2;
    logic [P3W-1:0] w_din_p3, w_data_p3;
    logic [MW-1:0]  w_magx_p1, w_magy_p1;
    logic           w_sof_p1, w_eof_p1, w_sof_p2, w_eof_p2;
    logic [SW-1:0]  w_sqx, w_sqy, w_sqx_p2, w_sqy_p2;
    logic [RW-1:0]  w_sum;

    assign s_ready = w_load_p1;

    // ---- input -> p1: clamped magnitudes and markers
    assign w_din_p1 = {clamp_mag(s_gx), clamp_mag(s_gy), s_sof, s_eof};

    grad_pipe_stage #(.W(P1W)) u_stage_p1 (
        .i_clk(clk_main), .i_rst(sys_rst),
        .i_valid(s_valid), .i_data(w_din_p1),
        .i_next_load(w_load_p2), .o_load(w_load_p1),
        .o_valid(w_vld_p1), .o_data(w_data_p1)
    );

    // ---- p1 -> p2: squares
    assign {w_magx_p1, w_magy_p1, w_sof_p1, w_eof_p1} = w_data_p1;
    assign w_sqx    = SW'(w_magx_p1) * SW'(w_magx_p1);
    assign w_sqy    = SW'(w_magy_p1) * SW'(w_magy_p1);
    assign w_din_p2 = {w_sqx, w_sqy, w_sof_p1, w_eof_p1};

    grad_pipe_stage #(.W(P2W)) u_stage_p2 (
        .i_clk(clk_main), .i_rst(sys_rst),
        .i_valid(w_vld_p1), .i_data(w_din_p2),
        .i_next_load(w_load_p3), .o_load(w_load_p2),
        .o_valid(w_vld_p2), .o_data(w_data_p2)
    );

    // ---- p2 -> p3: sum, drives the output port
    assign {w_sqx_p2, w_sqy_p2, w_sof_p2, w_eof_p2} = w_data_p2;
    assign w_sum    = RW'(w_sqx_p2) + RW'(w_sqy_p2);
    assign w_din_p3 = {w_sum, w_sof_p2, w_eof_p2};

    grad_pipe_stage #(.W(P3W)) u_stage_p3 (
        .i_clk(clk_main), .i_rst(sys_rst),
        .i_valid(w_vld_p2), .i_data(w_din_p3),
        .i_next_load(m_ready), .o_load(w_load_p3),
        .o_valid(m_valid), .o_data(w_data_p3)
    );

    assign {m_radical, m_sof, m_eof} = w_data_p3;

`ifdef GRAD_PEAK_EN
    function automatic logic [RW-1:0] max_u(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic          w_xfer;
    logic [RW-1:0] w_run_next;
    logic [RW-1:0] r_run_max, r_peak;
    logic          r_peak_valid;

    // A sof beat restarts the running max so a one-pixel frame reports itself.
    assign w_xfer     = m_valid && m_ready;
    assign w_run_next = m_sof ? m_radical : max_u(r_run_max, m_radical);

    always_ff @(posedge clk_main or posedge sys_rst) begin
        if (sys_rst) begin
            r_run_max    <= '0;
            r_peak       <= '0;
            r_peak_valid <= 1'b0;
        end else begin
            r_peak_valid <= 1'b0;
            if (w_xfer) begin
                r_run_max <= w_run_next;
                if (m_eof) begin
                    r_peak       <= w_run_next;
                    r_peak_valid <= 1'b1;
                end
            end
        end
    end

    assign peak       = r_peak;
    assign peak_valid = r_peak_valid;
`endif
endmodule

// File: tb/tb_grad_mag_sq.sv
// Scoreboard bench for grad_mag_sq: accepted inputs push the expected beat,
// an independent monitor pops and compares on every output transfer.
module tb_grad_mag_sq;
    import grad_pkg::*;

    logic                 clk_main = 1'b0;
    logic                 sys_rst;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [GW-1:0] s_gx, s_gy;
    logic                 s_sof, s_eof;
    logic                 m_valid;
    logic                 m_ready;
    logic [RW-1:0]        m_radical;
    logic                 m_sof, m_eof;
`ifdef GRAD_PEAK_EN
    logic [RW-1:0]        peak;
    logic                 peak_valid;
`endif

    grad_mag_sq #(.GW(GW), .RW(RW)) dut (
        .clk_main(clk_main), .sys_rst(sys_rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_gx(s_gx), .s_gy(s_gy), .s_sof(s_sof), .s_eof(s_eof),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_radical(m_radical), .m_sof(m_sof), .m_eof(m_eof)
`ifdef GRAD_PEAK_EN
        , .peak(peak), .peak_valid(peak_valid)
`endif
    );

    always #5 clk_main = ~clk_main;

    typedef struct {
        grad_beat_t beat;
        int         cyc;
        int         stl;
    } exp_t;

    exp_t sb[$];
    exp_t e_in, e_out;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
    int   last_rad = -1;
    int   n_out = 0;

    function automatic void check(string nm, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference: magnitude with the most negative code pinned to MAG_MAX.
    function automatic int model_rad(int gx, int gy);
        int ax, ay;
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        if (ax > MAG_MAX) ax = MAG_MAX;
        if (ay > MAG_MAX) ay = MAG_MAX;
        return ax * ax + ay * ay;
    endfunction

    always @(posedge clk_main) cyc <= cyc + 1;

    always @(negedge clk_main) begin
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 3) != 0);
            default: m_ready = 1'b0;
        endcase
    end

    // Stimulus side: push the expected beat for every accepted input.
    always begin
        @(negedge clk_main);
        #4;
        if (!m_ready) stall_cnt++;
        if (!sys_rst && s_valid && s_ready) begin
            e_in.beat.radical = RW'(model_rad(int'(s_gx), int'(s_gy)));
            e_in.beat.sof     = s_sof;
            e_in.beat.eof     = s_eof;
            e_in.cyc          = cyc;
            e_in.stl          = stall_cnt;
            sb.push_back(e_in);
        end
    end

    // Monitor side.
    logic          hold_v = 1'b0;
    logic [RW-1:0] hold_rad;
    logic          hold_sof, hold_eof;
`ifdef GRAD_PEAK_EN
    int frame_vals[$];
    bit peak_pend = 1'b0;
    int peak_exp;
`endif

    always begin
        @(negedge clk_main);
        #4;
        if (sys_rst) begin
            hold_v = 1'b0;
`ifdef GRAD_PEAK_EN
            peak_pend = 1'b0;
            frame_vals.delete();
`endif
        end else begin
            if (hold_v) begin
                check("stall_valid", longint'(m_valid), 1);
                check("stall_radical", longint'(m_radical), longint'(hold_rad));
                check("stall_sof", longint'(m_sof), longint'(hold_sof));
                check("stall_eof", longint'(m_eof), longint'(hold_eof));
            end
`ifdef GRAD_PEAK_EN
            if (peak_pend) begin
                check("peak_valid_pulse", longint'(peak_valid), 1);
                check("peak_value", longint'(peak), longint'(peak_exp));
                peak_pend = 1'b0;
            end else begin
                check("peak_valid_idle", longint'(peak_valid), 0);
            end
`endif
            hold_v   = m_valid && !m_ready;
            hold_rad = m_radical;
            hold_sof = m_sof;
            hold_eof = m_eof;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", longint'(m_valid), 0);
                end else begin
                    e_out = sb.pop_front();
                    check("radical", longint'(m_radical), longint'(e_out.beat.radical));
                    check("sof", longint'(m_sof), longint'(e_out.beat.sof));
                    check("eof", longint'(m_eof), longint'(e_out.beat.eof));
                    if (e_out.stl == stall_cnt) check("latency", cyc - e_out.cyc, 3);
                    last_rad = int'(m_radical);
                    n_out++;
`ifdef GRAD_PEAK_EN
                    if (e_out.beat.sof) frame_vals.delete();
                    frame_vals.push_back(int'(e_out.beat.radical));
                    if (e_out.beat.eof) begin
                        peak_exp = 0;
                        foreach (frame_vals[k]) if (frame_vals[k] > peak_exp) peak_exp = frame_vals[k];
                        peak_pend = 1'b1;
                    end
`endif
                end
            end
        end
    end

    task automatic send(input int gx, input int gy, input bit sof, input bit eof);
        bit acc;
        acc = 1'b0;
        @(negedge clk_main);
        s_gx    = GW'(gx);
        s_gy    = GW'(gy);
        s_sof   = sof;
        s_eof   = eof;
        s_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            #4;
            if (s_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk_main);
        end
        if (!acc) check("send_timeout", longint'(s_ready), 1);
        @(posedge clk_main);
        #1;
        s_valid = 1'b0;
    endtask

    // Returns at posedge+1 of the cycle after the scoreboard empties.
    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk_main);
            #6;
            if (sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", sb.size(), 0);
    endtask

    function automatic int rand_grad();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return -(1 << (GW - 1));
        if (r == 1) return MAG_MAX;
        return int'($urandom_range(0, (1 << GW) - 1)) - (1 << (GW - 1));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int out0;
        sys_rst = 1'b1;
        s_valid = 1'b0;
        s_gx = '0; s_gy = '0; s_sof = 1'b0; s_eof = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk_main);
        s_valid = 1'b1;   // ignored while in reset
        @(negedge clk_main);
        s_valid = 1'b0;
        sys_rst = 1'b0;
        #1;
        check("rst_m_valid", longint'(m_valid), 0);
        check("rst_m_radical", longint'(m_radical), 0);
        check("rst_m_sof", longint'(m_sof), 0);
        check("rst_m_eof", longint'(m_eof), 0);
        check("rst_s_ready", longint'(s_ready), 1);
`ifdef GRAD_PEAK_EN
        check("rst_peak", longint'(peak), 0);
        check("rst_peak_valid", longint'(peak_valid), 0);
`endif
        repeat (4) begin
            @(negedge clk_main);
            #6;
            check("rst_no_output", longint'(m_valid), 0);
        end

        // Single beat and clamp corners.
        send(3, 4, 1'b0, 1'b0);
        drain();
        check("single_value", last_rad, 25);
        check("single_pulse", longint'(m_valid), 0);
        send(-1024, -1024, 1'b0, 1'b0);
        drain();
        check("clamp_both_min", last_rad, 2093058);
        send(1023, 0, 1'b0, 1'b0);
        drain();
        check("max_pos", last_rad, 1046529);

        // Backpressure: 8 beats, m_ready low for 5 cycles mid-stream.
        out0 = n_out;
        for (int i = 0; i < 3; i++) send(i, 0, 1'b0, 1'b0);
        rdy_mode = 2;
        fork
            begin
                for (int i = 3; i < 8; i++) send(i, 0, 1'b0, 1'b0);
            end
            begin
                repeat (5) @(negedge clk_main);
                #4;
                check("bp_s_ready_low", longint'(s_ready), 0);
                check("bp_in_flight", sb.size(), 3);
                check("bp_m_valid", longint'(m_valid), 1);
                rdy_mode = 0;
            end
        join
        drain();
        check("bp_count", n_out - out0, 8);
        check("bp_last", last_rad, 49);

        // Frame markers.
        send(3, 4, 1'b1, 1'b0);
        send(0, 10, 1'b0, 1'b0);
        send(-3, 0, 1'b0, 1'b0);
        send(5, -5, 1'b0, 1'b1);
        drain();
        check("frame_last", last_rad, 50);
`ifdef GRAD_PEAK_EN
        check("frame_peak", longint'(peak), 100);
`endif
        send(7, 0, 1'b1, 1'b1);
        drain();
        check("one_pixel_frame", last_rad, 49);
`ifdef GRAD_PEAK_EN
        check("one_pixel_peak", longint'(peak), 49);
`endif

        // Randomized traffic with random backpressure and input gaps.
        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk_main);
            send(rand_grad(), rand_grad(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end
        rdy_mode = 0;
        drain();

        // Reset with three beats in flight.
        rdy_mode = 2;
        @(negedge clk_main);
        #1;
        send(9, 9, 1'b1, 1'b0);
        send(8, 8, 1'b0, 1'b0);
        send(7, 7, 1'b0, 1'b1);
        check("pre_reset_valid", longint'(m_valid), 1);
        @(negedge clk_main);
        #2;
        sys_rst = 1'b1;
        #1;
        check("async_rst_m_valid", longint'(m_valid), 0);
        check("async_rst_s_ready", longint'(s_ready), 1);
`ifdef GRAD_PEAK_EN
        check("async_rst_peak", longint'(peak), 0);
`endif
        sb.delete();
        repeat (2) @(negedge clk_main);
        #2;
        sys_rst = 1'b0;
        rdy_mode = 0;
        repeat (6) begin
            @(negedge clk_main);
            #6;
            check("post_rst_idle", longint'(m_valid), 0);
        end
        send(1, 1, 1'b0, 1'b0);
        drain();
        check("post_rst_value", last_rad, 2);
        repeat (3) @(negedge clk_main);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/grad_mag_sq.md
# grad_mag_sq

Pipelined gradient-energy stage that turns one signed Sobel gradient pair (gx, gy) per beat into the unsigned radical gx² + gy².
It sits directly upstream of the square-root stage and feeds that stage's 21-bit radical input.
- Throughput: one beat per clock under valid/ready flow control.
- Frame markers: start-of-frame and end-of-frame travel alongside the data.
- Optional monitor: a per-frame peak of the radical.

## Interface
Parameters:
- GW, 11, signed gradient width (Sobel 8-bit pixels need ±1020).
- RW, 21, radical width. Must equal 2*GW-1; an elaboration check fails otherwise.

Ports:
- clk_main  in  1  single clock. All logic is rising-edge.
- sys_rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  stage can accept a beat.
- s_gx  in  GW  signed horizontal gradient.
- s_gy  in  GW  signed vertical gradient.
- s_sof  in  1  beat is the first pixel of a frame.
- s_eof  in  1  beat is the last pixel of a frame.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts.
- m_radical  out  RW  unsigned gx²+gy².
- m_sof, m_eof  out  1 each  markers, aligned with m_radical.
- peak  out  RW  maximum radical of the last completed frame. Present only with GRAD_PEAK_EN.
- peak_valid  out  1  one-cycle pulse when peak updates. Present only with GRAD_PEAK_EN.

## Operation
- A transfer occurs on a rising edge where valid and ready are both high, on either side.
- Three register stages, each holding a valid bit:
  - S1: registers |gx| and |gy| as GW-1-bit magnitudes plus the markers.
  - S2: registers the two squares, each 2*GW-2 bits.
  - S3: registers the RW-bit sum. S3 drives the m_* outputs.
- Clamp rule: an input of -2^(GW-1) is treated as magnitude 2^(GW-1)-1.
  - This guarantees the sum never exceeds 2*(2^(GW-1)-1)² < 2^RW. No wrap-around is possible.
- Flow control is bubble-collapsing:
  - Stage k loads when it is empty or when stage k+1 is loading. S3 loads when it is empty or m_ready is high.
  - s_ready = !v1 || load2, so s_ready depends combinationally on m_ready through the chain.
- Data, sof and eof move as one beat. Beats are never reordered, dropped or duplicated.
- While m_valid is high and m_ready is low, m_radical, m_sof and m_eof hold stable.
- s_sof and s_eof on the same beat (a one-pixel frame) are legal and are passed through unchanged.

## Timing
- Latency: 3 clk_main cycles from input transfer to m_valid, with no stall.
- Throughput: one beat per cycle while m_ready stays high.
- Capacity: up to 3 beats in flight. With m_ready low, s_ready falls once S1–S3 are all full.
- Reset values:
  - m_valid = 0, m_radical = 0, m_sof = 0, m_eof = 0.
  - peak = 0, peak_valid = 0.
  - s_ready = 1 once reset is released.
- Reset mid-operation:
  - All stage valid bits clear immediately (asynchronously) and in-flight beats are discarded.
  - The peak accumulator clears.
  - After release, no output appears until a new input is accepted.
- s_valid asserted during reset is ignored.

## Configuration
- The macro GRAD_PEAK_EN controls the per-frame peak monitor.
- Defined:
  - A running-max register updates on every output transfer.
  - A transfer with m_sof loads the running max with that beat's radical.
  - A transfer with m_eof loads peak with max(running max, radical) and pulses peak_valid high for exactly that cycle.
  - A beat carrying both sof and eof sets peak to its own radical.
- Undefined: the peak and peak_valid ports and all monitor logic are absent. Datapath behaviour is identical.

## Structure
- Package grad_pkg holds:
  - GW, RW and the clamp constant MAG_MAX = 2^(GW-1)-1.
  - The beat typedef (radical/magnitude payload, sof, eof), shared with the sqrt stage's testbench.
- Sub-module grad_pipe_stage: a generic valid/ready register slice (payload, valid, load-enable logic). It is instantiated three times with different payload widths.

## Test plan
- gx=3, gy=4, single beat, m_ready=1 → m_radical=25 with m_valid high 3 cycles after the transfer, for exactly one cycle.
- gx=-1024, gy=-1024 → m_radical=2093058 (clamped, no overflow). gx=1023, gy=0 → 1046529.
- Backpressure: stream 8 beats gx=0..7, gy=0, hold m_ready low for 5 cycles mid-stream.
  - s_ready must fall once 3 beats are held.
  - Outputs must be 0,1,4,…,49 in order, with none lost or repeated.
  - Held outputs stay stable while stalled.
- Markers: a 4-beat frame with radicals 25,100,9,50, sof on the first beat, eof on the last.
  - m_sof/m_eof appear on the same beats.
  - With GRAD_PEAK_EN: peak=100 and peak_valid pulses once on the eof transfer.
- Reset mid-stream: assert sys_rst with 3 beats in flight.
  - m_valid drops to 0 without waiting for a clock edge, and peak = 0.
  - After release there is no output until new input; the next beat gx=1, gy=1 yields 2.
